mem_arbiter_prio: RTL and testbench
===================================

# mem_arbiter_prio

Parametrised successor to the two-port memory arbiter inside `cpu`. It multiplexes `CNT` decoupled master request channels onto one slave memory port. Grant policy is round-robin with an optional privileged master (the data-memory port of `execute`), bounded by an anti-starvation limit. Responses are routed back in issue order through an outstanding-transaction FIFO, and a per-master `discard` drops responses to requests made stale by a pipeline flush.

## Interface
- `CNT`, default 2: number of masters, ≥1.
- `QUEUE_DEPTH`, default 4: maximum outstanding slave transactions, ≥1.
- `PRIO_EN`, default 1: 1 enables strict priority for `PRIO_MASTER`.
- `PRIO_MASTER`, default 0: index of the privileged master, < `CNT`.
- `STARVE_LIMIT`, default 4: consecutive contested priority grants before one forced round-robin grant, ≥1.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low (asserted at 0).
- `master_req[CNT]`, decoupled.in, `mreq`: per-master requests.
- `master_resp[CNT]`, decoupled.out, `mtrans`: per-master responses.
- `slave_req`, decoupled.out, `mreq`: request to memory.
- `slave_resp`, decoupled.in, `mtrans`: memory response, in request order.
- `discard`, in, `CNT`: bit i set = mark every outstanding master-i transaction as drop.

## Operation
State:
- Order FIFO: `QUEUE_DEPTH` entries, each holding master index plus drop bit.
- Count: `$clog2(QUEUE_DEPTH+1)` bits.
- Round-robin pointer `rr`: `$clog2(CNT)` bits, min 1.
- Starvation counter `sc`: `$clog2(STARVE_LIMIT+1)` bits.

Grant (combinational):
- Let V = set of masters with `valid` set.
- If `PRIO_EN`, `PRIO_MASTER`∈V and `sc` < `STARVE_LIMIT`: grant `PRIO_MASTER`.
- Otherwise: grant the first index in V scanning `rr`, `rr+1`, … mod `CNT`, excluding `PRIO_MASTER` when V contains other masters and `sc` = `STARVE_LIMIT`.

Request path:
- `slave_req.valid` = V nonempty and FIFO not full.
- `slave_req.data` = granted master's data.
- `master_req[g].ready` = `slave_req.ready` and not full; all others 0.
- Full blocks push even if a pop happens in the same cycle.

On a request fire (rising edge):
- Push {g, drop = `discard[g]`}.
- `rr` ← (g+1) mod `CNT`.
- If g = `PRIO_MASTER` and another master was also valid: `sc` ← `sc`+1, saturating.
- Otherwise: `sc` ← 0.

Response path (head entry h):
- FIFO empty: `slave_resp.ready` = 0, all `master_resp.valid` = 0.
- h.drop: `slave_resp.ready` = 1, nothing forwarded, pop on fire.
- Otherwise: `master_resp[h.idx].valid` = `slave_resp.valid`, data passed through, `slave_resp.ready` = `master_resp[h.idx].ready`, pop on fire.

Discard:
- `discard[i]` sets drop on every valid FIFO entry with idx = i, including the head this cycle.
- The head's drop takes effect next cycle, so a response delivered in the discard cycle is still forwarded.
- A request fired in the same cycle as its master's discard is pushed with drop = 1.

Reset:
- While `rst` = 0, FIFO is emptied and `rr`, `sc` and count are 0.
- While `rst` = 0, all ready/valid outputs are forced to 0.
- Mid-operation reset abandons all outstanding transactions; the memory side is reset together with this block.

## Timing
- Zero-cycle combinational request and response paths; no added latency.
- New state is visible the cycle after a fire.
- Simultaneous push and pop when not full: count unchanged, both entries are handled correctly.
- Pointer wrap: `rr` at `CNT-1` wraps to 0.
- With `CNT` = 1: `rr` is constant 0, and the grant always selects master 0 when it is valid.

## Test plan
- Round-robin fairness: `CNT`=3, `PRIO_EN`=0, all masters always valid, slave always ready -> grants 0,1,2,0,1,2.
- Priority with starvation limit: `PRIO_MASTER`=0, `STARVE_LIMIT`=3, masters 0 and 1 always valid -> grants 0,0,0,1,0,0,0,1.
- In-order routing: m1 request fires, then m0; slave returns A then B -> m1 receives A, m0 receives B; `master_resp[1]` held not-ready stalls `slave_resp` while A is pending.
- Discard: m1 has 2 outstanding; `discard[1]` pulses while a third m1 request fires -> all 3 responses are accepted with `slave_resp.ready`=1 and `master_resp[1].valid` never set; the next m1 request's response is delivered.
- Full boundary: `QUEUE_DEPTH`=2, two requests outstanding -> `slave_req.valid`=0 and all `master_req.ready`=0; after one response fires, the next request is accepted the following cycle.
- Reset mid-operation: 2 outstanding, `rst` driven 0 for one cycle -> all outputs 0 during reset; after release the FIFO is empty, the first grant goes to master 0, and a stale response with `slave_resp.valid`=1 sees `ready`=0.

Source files
------------

// File: rtl/mem_arbiter_prio.sv
// Round-robin memory arbiter with a privileged master and starvation guard.
// Responses return in issue order through an order FIFO with per-entry drop.
module mem_arbiter_prio #(
  parameter int CNT          = 2,
  parameter int QUEUE_DEPTH  = 4,
  parameter int PRIO_EN      = 1,
  parameter int PRIO_MASTER  = 0,
  parameter int STARVE_LIMIT = 4,
  parameter int REQ_W        = 32,
  parameter int RESP_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT-1:0]               master_req_valid,
  output logic [CNT-1:0]               master_req_ready,
  input  logic [CNT-1:0][REQ_W-1:0]    master_req_data,
  output logic [CNT-1:0]               master_resp_valid,
  input  logic [CNT-1:0]               master_resp_ready,
  output logic [CNT-1:0][RESP_W-1:0]   master_resp_data,
  output logic                         slave_req_valid,
  input  logic                         slave_req_ready,
  output logic [REQ_W-1:0]             slave_req_data,
  input  logic                         slave_resp_valid,
  output logic                         slave_resp_ready,
  input  logic [RESP_W-1:0]            slave_resp_data,
  input  logic [CNT-1:0]               discard
);

  localparam int IW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [QUEUE_DEPTH-1:0][IW-1:0] idx_q, idx_d;
  logic [QUEUE_DEPTH-1:0]         drop_q, drop_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [IW-1:0]                  rr_q, rr_d;
  logic [SW-1:0]                  sc_q, sc_d;

  logic [CNT-1:0] pm_mask;
  logic           others;
  logic           excl;
  logic           found;
  int             gnt;
  int             scan;
  logic           full;
  logic           empty;
  logic           any_v;
  logic [IW-1:0]  head_idx;
  logic           head_drop;
  logic           push;
  logic           pop;

  always_comb begin
    pm_mask = '0;
    pm_mask[PRIO_MASTER] = 1'b1;
    others = |(master_req_valid & ~pm_mask);
    excl   = (PRIO_EN != 0) && others && (sc_q == SW'(STARVE_LIMIT));
    found  = 1'b0;
    gnt    = 0;
    scan   = 0;
    if ((PRIO_EN != 0) && master_req_valid[PRIO_MASTER] &&
        (sc_q < SW'(STARVE_LIMIT))) begin
      gnt   = PRIO_MASTER;
      found = 1'b1;
    end
    for (int k = 0; k < CNT; k++) begin
      scan = (int'(rr_q) + k) % CNT;
      if (!found && master_req_valid[scan] &&
          !(excl && scan == PRIO_MASTER)) begin
        gnt   = scan;
        found = 1'b1;
      end
    end
  end

  assign full      = (cnt_q == CW'(QUEUE_DEPTH));
  assign empty     = (cnt_q == '0);
  assign any_v     = |master_req_valid;
  assign head_idx  = idx_q[0];
  assign head_drop = drop_q[0];

  always_comb begin
    slave_req_valid  = rst && any_v && !full;
    slave_req_data   = master_req_data[gnt];
    master_req_ready = '0;
    if (rst && any_v && slave_req_ready && !full)
      master_req_ready[gnt] = 1'b1;
    slave_resp_ready = rst && !empty &&
                       (head_drop || master_resp_ready[head_idx]);
    master_resp_valid = '0;
    if (rst && !empty && !head_drop)
      master_resp_valid[head_idx] = slave_resp_valid;
    for (int i = 0; i < CNT; i++)
      master_resp_data[i] = slave_resp_data;
  end

  assign push = slave_req_valid && slave_req_ready;
  assign pop  = slave_resp_valid && slave_resp_ready;

  // Shift FIFO: slot 0 is always the head, slots below cnt_q are live.
  always_comb begin
    idx_d  = idx_q;
    drop_d = drop_q;
    for (int j = 0; j < QUEUE_DEPTH; j++)
      if (j < int'(cnt_q) && discard[idx_q[j]])
        drop_d[j] = 1'b1;
    if (pop) begin
      for (int j = 0; j < QUEUE_DEPTH - 1; j++) begin
        idx_d[j]  = idx_d[j+1];
        drop_d[j] = drop_d[j+1];
      end
    end
    if (push) begin
      idx_d[int'(cnt_q) - (pop ? 1 : 0)]  = IW'(gnt);
      drop_d[int'(cnt_q) - (pop ? 1 : 0)] = discard[gnt];
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    rr_d = rr_q;
    sc_d = sc_q;
    if (push) begin
      rr_d = IW'((gnt + 1) % CNT);
      if ((PRIO_EN != 0) && gnt == PRIO_MASTER && others)
        sc_d = (sc_q < SW'(STARVE_LIMIT)) ? sc_q + 1'b1 : sc_q;
      else
        sc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
      sc_q   <= '0;
    end else begin
      idx_q  <= idx_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      sc_q   <= sc_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_prio.sv
// Random-stimulus bench for mem_arbiter_prio against a queue-based
// reference of the grant, ordering and discard rules.
module tb_mem_arbiter_prio;

  localparam int CNT = 3;
  localparam int QD  = 3;
  localparam int PM  = 1;
  localparam int SL  = 2;
  localparam int RW  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [CNT-1:0]        mreq_valid;
  logic [CNT-1:0]        mreq_ready;
  logic [CNT-1:0][RW-1:0] mreq_data;
  logic [CNT-1:0]        mresp_valid;
  logic [CNT-1:0]        mresp_ready;
  logic [CNT-1:0][RW-1:0] mresp_data;
  logic                  sreq_valid;
  logic                  sreq_ready;
  logic [RW-1:0]         sreq_data;
  logic                  sresp_valid;
  logic                  sresp_ready;
  logic [RW-1:0]         sresp_data;
  logic [CNT-1:0]        discard;

  mem_arbiter_prio #(
    .CNT(CNT), .QUEUE_DEPTH(QD), .PRIO_EN(1), .PRIO_MASTER(PM),
    .STARVE_LIMIT(SL), .REQ_W(RW), .RESP_W(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .master_req_valid(mreq_valid), .master_req_ready(mreq_ready),
    .master_req_data(mreq_data),
    .master_resp_valid(mresp_valid), .master_resp_ready(mresp_ready),
    .master_resp_data(mresp_data),
    .slave_req_valid(sreq_valid), .slave_req_ready(sreq_ready),
    .slave_req_data(sreq_data),
    .slave_resp_valid(sresp_valid), .slave_resp_ready(sresp_ready),
    .slave_resp_data(sresp_data),
    .discard(discard)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit drop;
  } ent_t;

  ent_t q[$];
  int   rr;
  int   sc;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rand(input int pv);
    for (int i = 0; i < CNT; i++) begin
      mreq_valid[i]  = ($urandom_range(0, 9) < pv);
      mreq_data[i]   = RW'($urandom);
      mresp_ready[i] = ($urandom_range(0, 9) < 7);
      discard[i]     = ($urandom_range(0, 29) == 0);
    end
    sreq_ready  = ($urandom_range(0, 9) < 7);
    sresp_valid = ($urandom_range(0, 9) < 6);
    sresp_data  = RW'($urandom);
  endtask

  // Expected outputs come from the grant/order rules applied to the queue.
  task automatic step_model();
    logic [CNT-1:0] e_mready;
    logic [CNT-1:0] e_mrv;
    bit   others;
    bit   full;
    bit   any_v;
    bit   e_srv;
    bit   e_srr;
    bit   push;
    bit   pop;
    int   g;
    int   c;
    bit   got_g;
    ent_t e;
    e_mready = '0;
    e_mrv    = '0;
    if (!rst) begin
      chk("rst_sreq_valid", 32'(sreq_valid), 0);
      chk("rst_mreq_ready", 32'(mreq_ready), 0);
      chk("rst_sresp_ready", 32'(sresp_ready), 0);
      chk("rst_mresp_valid", 32'(mresp_valid), 0);
      q.delete();
      rr = 0;
      sc = 0;
      return;
    end
    any_v  = |mreq_valid;
    others = 0;
    for (int i = 0; i < CNT; i++)
      if (i != PM && mreq_valid[i]) others = 1;
    full  = (q.size() == QD);
    g     = 0;
    got_g = 0;
    if (mreq_valid[PM] && sc < SL) begin
      g = PM;
      got_g = 1;
    end
    for (int k = 0; k < CNT; k++) begin
      c = (rr + k) % CNT;
      if (!got_g && mreq_valid[c] && !(others && sc == SL && c == PM)) begin
        g = c;
        got_g = 1;
      end
    end
    e_srv = any_v && !full;
    if (e_srv && sreq_ready) e_mready[g] = 1'b1;
    e_srr = 0;
    if (q.size() != 0) begin
      e_srr = q[0].drop ? 1'b1 : mresp_ready[q[0].idx];
      if (!q[0].drop) e_mrv[q[0].idx] = sresp_valid;
    end
    chk("sreq_valid", 32'(sreq_valid), 32'(e_srv));
    chk("mreq_ready", 32'(mreq_ready), 32'(e_mready));
    chk("sresp_ready", 32'(sresp_ready), 32'(e_srr));
    chk("mresp_valid", 32'(mresp_valid), 32'(e_mrv));
    if (e_srv) chk("sreq_data", 32'(sreq_data), 32'(mreq_data[g]));
    if (e_mrv != '0)
      chk("mresp_data", 32'(mresp_data[q[0].idx]), 32'(sresp_data));
    push = e_srv && sreq_ready;
    pop  = sresp_valid && e_srr;
    foreach (q[i]) if (discard[q[i].idx]) q[i].drop = 1;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.idx  = g;
      e.drop = discard[g];
      q.push_back(e);
      rr = (g + 1) % CNT;
      if (g == PM && others) sc = (sc < SL) ? sc + 1 : sc;
      else sc = 0;
    end
  endtask

  initial begin
    rst = 1'b0;
    mreq_valid = '1;
    mreq_data = '0;
    mresp_ready = '1;
    sreq_ready = 1'b1;
    sresp_valid = 1'b1;
    sresp_data = '0;
    discard = '0;
    q.delete();
    rr = 0;
    sc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step_model();
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      rst = !(cyc == 1500 || cyc == 2700 || $urandom_range(0, 299) == 0);
      drive_rand((cyc < 1000) ? 10 : ((cyc < 2500) ? 7 : 4));
      if (cyc < 600) begin
        sreq_ready = 1'b1;
        discard = '0;
      end
      @(negedge clk);
      step_model();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
